buzzer_sequencer: RTL and testbench

// Autonomous melody/event player in front of Buzzer16. Fetches a list of 2-word events from

---
 rtl/buzzer_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_buzzer_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/buzzer_sequencer.sv
// Autonomous event-list player for Buzzer16: fetches 2-word events over the DMA read
// handshake, strobes each command into Buzzer16, then holds for the event duration in ticks.
module buzzer_sequencer #(
    parameter int unsigned TICK_DIV = 50000,
    parameter logic [7:0]  END_OP   = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ctrl_start,
    input  logic        ctrl_stop,
    input  logic        ctrl_loop,
    input  logic [15:0] ctrl_base,
    output logic        busy,
    output logic        done,
    output logic [15:0] addrDMA,
    output logic        startDMA,
    input  logic [15:0] inDMA,
    input  logic        rdyDMA,
    output logic        buz_start,
    output logic [23:0] buz_in
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRE_FIRST = (TICK_DIV > 1) ? PW'(1) : '0;
    localparam logic [7:0]    TICK_FIRST = (TICK_DIV > 1) ? 8'd0 : 8'd1;
    localparam logic [23:0]   STOP_CMD  = 24'h020000;

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        W0,
        RD1,
        W1,
        ISSUE,
        HOLD,
        STOPCMD
    } stateT;

    stateT         state;
    stateT         nextState;
    logic [15:0]   ptr;
    logic [15:0]   base;
    logic          loopFlag;
    logic [7:0]    opcode;
    logic [7:0]    dur;
    logic [15:0]   arg;
    logic [PW-1:0] prescale;
    logic [7:0]    tickCnt;
    logic          stopPend;

    logic stopReq;
    logic isEnd;
    logic holdLast;
    logic issueLast;
    logic startOk;

    always_comb begin
        stopReq   = stopPend | ctrl_stop;
        isEnd     = (inDMA[15:8] == END_OP);
        startOk   = ctrl_start & ~ctrl_stop;
        holdLast  = (prescale == PRE_LAST) && (({1'b0, tickCnt} + 9'd1) == {1'b0, dur});
        issueLast = (dur == 8'd0) || ((dur == 8'd1) && (TICK_DIV == 1));

        nextState = state;
        busy      = (state != IDLE);
        done      = 1'b0;
        startDMA  = 1'b0;
        addrDMA   = '0;
        buz_start = 1'b0;
        buz_in    = '0;

        case (state)
            IDLE: begin
                if (startOk) nextState = RD0;
            end
            RD0: begin
                startDMA  = 1'b1;
                addrDMA   = ptr;
                nextState = W0;
            end
            W0: begin
                addrDMA = ptr;
                if (rdyDMA) begin
                    if (stopReq) begin
                        nextState = STOPCMD;
                    end else if (isEnd) begin
                        if (loopFlag) begin
                            nextState = RD0;
                        end else begin
                            nextState = IDLE;
                            done      = 1'b1;
                        end
                    end else begin
                        nextState = RD1;
                    end
                end
            end
            RD1: begin
                startDMA  = 1'b1;
                addrDMA   = ptr + 16'd1;
                nextState = W1;
            end
            W1: begin
                addrDMA = ptr + 16'd1;
                if (rdyDMA) nextState = stopReq ? STOPCMD : ISSUE;
            end
            ISSUE: begin
                buz_start = 1'b1;
                buz_in    = {opcode, arg};
                if (stopReq)        nextState = STOPCMD;
                else if (issueLast) nextState = RD0;
                else                nextState = HOLD;
            end
            HOLD: begin
                if (stopReq)       nextState = STOPCMD;
                else if (holdLast) nextState = RD0;
            end
            STOPCMD: begin
                buz_start = 1'b1;
                buz_in    = STOP_CMD;
                done      = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ptr      <= '0;
            base     <= '0;
            loopFlag <= 1'b0;
            opcode   <= '0;
            dur      <= '0;
            arg      <= '0;
            prescale <= '0;
            tickCnt  <= '0;
            stopPend <= 1'b0;
        end else begin
            state <= nextState;

            if ((state == IDLE) || (state == STOPCMD)) stopPend <= 1'b0;
            else if (ctrl_stop)                        stopPend <= 1'b1;

            case (state)
                IDLE: begin
                    if (startOk) begin
                        base     <= ctrl_base;
                        loopFlag <= ctrl_loop;
                        ptr      <= ctrl_base;
                    end
                end
                W0: begin
                    if (rdyDMA) begin
                        opcode <= inDMA[15:8];
                        dur    <= inDMA[7:0];
                        if (isEnd && loopFlag) ptr <= base;
                    end
                end
                W1: begin
                    if (rdyDMA) arg <= inDMA;
                end
                ISSUE: begin
                    // ISSUE is the first counted hold cycle, so strobe-to-next-fetch is duration*TICK_DIV
                    ptr      <= ptr + 16'd2;
                    prescale <= PRE_FIRST;
                    tickCnt  <= TICK_FIRST;
                end
                HOLD: begin
                    if (prescale == PRE_LAST) begin
                        prescale <= '0;
                        tickCnt  <= tickCnt + 8'd1;
                    end else begin
                        prescale <= prescale + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_buzzer_sequencer.sv
// Bench for buzzer_sequencer: timeline model of expected outputs per cycle plus literal pins.
module tb_buzzer_sequencer;

    localparam int TD   = 4;
    localparam int MAXC = 128;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ctrl_start = 1'b0;
    logic        ctrl_stop  = 1'b0;
    logic        ctrl_loop  = 1'b0;
    logic [15:0] ctrl_base  = '0;
    logic        busy;
    logic        done;
    logic [15:0] addrDMA;
    logic        startDMA;
    logic [15:0] inDMA  = 16'hDEAD;
    logic        rdyDMA = 1'b0;
    logic        buz_start;
    logic [23:0] buz_in;

    buzzer_sequencer #(.TICK_DIV(TD), .END_OP(8'hFF)) dut (
        .clk(clk), .rst(rst),
        .ctrl_start(ctrl_start), .ctrl_stop(ctrl_stop), .ctrl_loop(ctrl_loop),
        .ctrl_base(ctrl_base), .busy(busy), .done(done),
        .addrDMA(addrDMA), .startDMA(startDMA), .inDMA(inDMA), .rdyDMA(rdyDMA),
        .buz_start(buz_start), .buz_in(buz_in)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s [%0d]: actual %0h required %0h", name, idx, act, exp);
        end
    endtask

    logic [15:0] mem [0:65535];

    // Memory responder: rdyDMA two cycles after the startDMA cycle.
    logic [15:0] rdAddr;
    always begin
        @(negedge clk);
        if (rst && startDMA) begin
            rdAddr = addrDMA;
            @(posedge clk);
            @(posedge clk);
            #1;
            rdyDMA = 1'b1;
            inDMA  = mem[rdAddr];
            @(posedge clk);
            #1;
            rdyDMA = 1'b0;
            inDMA  = 16'hDEAD;
        end
    end

    // Expected per-cycle outputs, index 0 = the cycle ctrl_start is presented.
    bit          eBusy  [MAXC];
    bit          eDone  [MAXC];
    bit          eSd    [MAXC];
    bit          eAddrV [MAXC];
    logic [15:0] eAddr  [MAXC];
    bit          eBuz   [MAXC];
    logic [23:0] eBuzIn [MAXC];

    task automatic expectRead(input int c, input logic [15:0] a);
        for (int k = 0; k < 3; k++) begin
            if (c + k < MAXC) begin
                eAddrV[c + k] = 1'b1;
                eAddr[c + k]  = a;
            end
        end
        if (c < MAXC) eSd[c] = 1'b1;
    endtask

    task automatic expectStrobe(input int c, input logic [23:0] v, input bit withDone);
        if (c < MAXC) begin
            eBuz[c]   = 1'b1;
            eBuzIn[c] = v;
            eDone[c]  = withDone;
        end
    endtask

    task automatic buildModel(input logic [15:0] base, input bit loop, input bit doStart, input int stopIdx);
        logic [15:0] ptr;
        logic [15:0] w0;
        logic [15:0] arg;
        int c;
        int gap;
        int last;
        bit fin;
        for (int i = 0; i < MAXC; i++) begin
            eBusy[i] = 0; eDone[i] = 0; eSd[i] = 0; eAddrV[i] = 0;
            eAddr[i] = '0; eBuz[i] = 0; eBuzIn[i] = '0;
        end
        if (doStart && stopIdx != 0) begin
            ptr = base; c = 1; fin = 0; last = MAXC - 1;
            while (!fin && c < MAXC) begin
                expectRead(c, ptr);
                w0 = mem[ptr];
                if (stopIdx > 0 && stopIdx <= c + 2) begin
                    expectStrobe(c + 3, 24'h020000, 1'b1); last = c + 3; fin = 1;
                end else if (w0[15:8] == 8'hFF) begin
                    if (loop) begin
                        ptr = base; c = c + 3;
                    end else begin
                        if (c + 2 < MAXC) eDone[c + 2] = 1'b1;
                        last = c + 2; fin = 1;
                    end
                end else begin
                    expectRead(c + 3, ptr + 16'd1);
                    arg = mem[ptr + 16'd1];
                    if (stopIdx > 0 && stopIdx <= c + 5) begin
                        expectStrobe(c + 6, 24'h020000, 1'b1); last = c + 6; fin = 1;
                    end else begin
                        expectStrobe(c + 6, {w0[15:8], arg}, 1'b0);
                        ptr = ptr + 16'd2;
                        gap = int'(w0[7:0]) * TD;
                        if (gap < 1) gap = 1;
                        if (stopIdx >= c + 6 && stopIdx < c + 6 + gap) begin
                            expectStrobe(stopIdx + 1, 24'h020000, 1'b1); last = stopIdx + 1; fin = 1;
                        end else begin
                            c = c + 6 + gap;
                        end
                    end
                end
            end
            for (int i = 1; i <= last && i < MAXC; i++) eBusy[i] = 1'b1;
        end
    endtask

    // Logs of observed DUT activity for the literal pins.
    int          strobeT[$];
    logic [23:0] strobeV[$];
    int          sdT[$];
    logic [15:0] addrLog[$];
    int          doneT[$];

    function automatic int tAt(input int i);
        return (i < strobeT.size()) ? strobeT[i] : -1000;
    endfunction
    function automatic logic [23:0] vAt(input int i);
        return (i < strobeV.size()) ? strobeV[i] : 24'hFFFFFF;
    endfunction
    function automatic int sdAt(input int i);
        return (i < sdT.size()) ? sdT[i] : -1000;
    endfunction
    function automatic int dAt(input int i);
        return (i < doneT.size()) ? doneT[i] : -1000;
    endfunction
    function automatic logic [15:0] aAt(input int i);
        return (i < addrLog.size()) ? addrLog[i] : 16'hBAD0;
    endfunction

    bit chk = 0;
    int t0 = 0;
    int runLen = 0;
    int idx;

    always @(negedge clk) begin
        if (chk && (cyc - t0) < runLen) begin
            idx = cyc - t0;
            check("busy", idx, busy, eBusy[idx]);
            check("done", idx, done, eDone[idx]);
            check("startDMA", idx, startDMA, eSd[idx]);
            check("buz_start", idx, buz_start, eBuz[idx]);
            check("buz_in", idx, buz_in, eBuzIn[idx]);
            if (eAddrV[idx]) check("addrDMA", idx, addrDMA, eAddr[idx]);
            if (startDMA) begin
                sdT.push_back(idx);
                addrLog.push_back(addrDMA);
            end
            if (buz_start) begin
                strobeT.push_back(idx);
                strobeV.push_back(buz_in);
            end
            if (done) doneT.push_back(idx);
        end
    end

    task automatic runScenario(input logic [15:0] base, input bit loop, input bit doStart,
                               input int stopIdx, input int len);
        buildModel(base, loop, doStart, stopIdx);
        strobeT.delete(); strobeV.delete(); sdT.delete(); addrLog.delete(); doneT.delete();
        @(posedge clk);
        #1;
        t0 = cyc; runLen = len; chk = 1;
        ctrl_start = doStart; ctrl_loop = loop; ctrl_base = base;
        ctrl_stop = (stopIdx == 0);
        for (int i = 1; i < len; i++) begin
            @(posedge clk);
            #1;
            ctrl_start = 1'b0;
            ctrl_stop  = (i == stopIdx);
        end
        @(posedge clk);
        #1;
        ctrl_stop = 1'b0;
        chk = 0;
    endtask

    task automatic checkQuiet(input string name);
        check({name, ".busy"}, 0, busy, 0);
        check({name, ".done"}, 0, done, 0);
        check({name, ".startDMA"}, 0, startDMA, 0);
        check({name, ".addrDMA"}, 0, addrDMA, 0);
        check({name, ".buz_start"}, 0, buz_start, 0);
        check({name, ".buz_in"}, 0, buz_in, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual no finish by %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'hFF00;
        #2;
        checkQuiet("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Single event with 3-tick hold, then END.
        mem[16'h0100] = 16'h0103; mem[16'h0101] = 16'h0045; mem[16'h0102] = 16'hFF00;
        runScenario(16'h0100, 1'b0, 1'b1, -1, 30);
        check("A.nStrobe", 0, strobeT.size(), 1);
        check("A.cmd", 0, vAt(0), 24'h010045);
        check("A.holdGap", 0, sdAt(2) - tAt(0), 12);
        check("A.doneAt", 0, dAt(0), 21);

        // Zero-duration event followed immediately by the next.
        mem[16'h0200] = 16'h0300; mem[16'h0201] = 16'h0005;
        mem[16'h0202] = 16'h0102; mem[16'h0203] = 16'h0230; mem[16'h0204] = 16'hFF00;
        runScenario(16'h0200, 1'b0, 1'b1, -1, 30);
        check("B.cmd0", 0, vAt(0), 24'h030005);
        check("B.cmd1", 0, vAt(1), 24'h010230);
        check("B.spacing", 0, tAt(1) - tAt(0), 7);

        // Looping list, stopped during W1 of the fourth pass.
        runScenario(16'h0200, 1'b1, 1'b1, 78, 85);
        check("C.nStrobe", 0, strobeT.size(), 7);
        check("C.first", 0, tAt(0), 7);
        check("C.period1", 0, tAt(2) - tAt(0), 24);
        check("C.period2", 0, tAt(4) - tAt(2), 24);
        check("C.stopCmd", 0, vAt(6), 24'h020000);
        check("C.nDone", 0, doneT.size(), 1);

        // Stop during W1: read finishes, command suppressed, STOP issued.
        runScenario(16'h0100, 1'b0, 1'b1, 5, 12);
        check("D.nStrobe", 0, strobeV.size(), 1);
        check("D.stopCmd", 0, vAt(0), 24'h020000);
        check("D.doneAt", 0, dAt(0), 7);

        // Stop alone in IDLE, and start+stop together.
        runScenario(16'h0100, 1'b0, 1'b0, 0, 8);
        check("E.nStrobe", 0, strobeT.size() + sdT.size() + doneT.size(), 0);
        runScenario(16'h0100, 1'b0, 1'b1, 0, 8);
        check("F.nStrobe", 0, strobeT.size() + sdT.size() + doneT.size(), 0);

        // Address wrap from FFFF to 0000.
        mem[16'hFFFE] = 16'h0101; mem[16'hFFFF] = 16'h0011; mem[16'h0000] = 16'hFF00;
        runScenario(16'hFFFE, 1'b0, 1'b1, -1, 20);
        check("G.nRead", 0, addrLog.size(), 3);
        check("G.addr0", 0, aAt(0), 16'hFFFE);
        check("G.addr1", 0, aAt(1), 16'hFFFF);
        check("G.addr2", 0, aAt(2), 16'h0000);
        check("G.cmd", 0, vAt(0), 24'h010011);

        // Asynchronous reset in HOLD, then a fresh run.
        runScenario(16'h0100, 1'b0, 1'b1, -1, 10);
        check("H.preBusy", 0, busy, 1);
        #2;
        rst = 1'b0;
        #1;
        checkQuiet("H.reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        runScenario(16'h0200, 1'b0, 1'b1, -1, 30);
        check("H.cmd1", 0, vAt(1), 24'h010230);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
